// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port video RAM between a prefetching show-ahead
// pixel FIFO for VGA scanout and a CPU bus port, with display priority when the FIFO runs low.
module vga_vram_arbiter #(
    parameter int RES_X      = 640,
    parameter int RES_Y      = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [31:0]       pix_data,
    output logic              underrun,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W:0] PIXELS = (ADDR_W+1)'(RES_X * RES_Y);
    localparam logic [CW:0]     LOW    = (CW+1)'(LOW_WM);
    localparam logic [CW:0]     DEPTH  = (CW+1)'(FIFO_DEPTH);

    logic [31:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [ADDR_W:0] fetch_addr;
    logic            fetch_active, inflight, cpu_rd_pend;
    logic [CW:0]     occ;
    logic            urgent, disp_rd, push, pop;

    // Occupancy includes the read in flight so a returning word always has a free slot.
    always_comb begin
        occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
        urgent    = fetch_active && occ < LOW;
        cpu_ready = rst_n && cpu_valid && !urgent;
        disp_rd   = fetch_active && !cpu_ready && occ < DEPTH;
        mem_en    = disp_rd || cpu_ready;
        mem_we    = cpu_ready && cpu_we;
        mem_addr  = disp_rd ? fetch_addr[ADDR_W-1:0] : cpu_ready ? cpu_addr : '0;
        mem_wdata = cpu_ready ? cpu_wdata : '0;
        pix_data  = count != '0 ? fifo_mem[rd_ptr] : '0;
        push      = inflight && !frame_start;
        pop       = pix_req && count != '0 && !frame_start;
    end

    always_ff @(posedge clk)
        if (push) fifo_mem[wr_ptr] <= mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            fetch_addr   <= '0;
            fetch_active <= 1'b0;
            inflight     <= 1'b0;
            cpu_rd_pend  <= 1'b0;
            cpu_rvalid   <= 1'b0;
            cpu_rdata    <= '0;
            underrun     <= 1'b0;
        end else begin
            cpu_rd_pend <= cpu_ready && !cpu_we;
            cpu_rvalid  <= cpu_rd_pend;
            if (cpu_rd_pend) cpu_rdata <= mem_rdata;
            if (pix_req && count == '0 && !frame_start) underrun <= 1'b1;
            if (frame_start) begin
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count        <= '0;
                fetch_addr   <= '0;
                fetch_active <= 1'b1;
                inflight     <= 1'b0;
            end else begin
                inflight <= disp_rd;
                if (disp_rd) begin
                    fetch_addr <= fetch_addr + 1'b1;
                    if (fetch_addr + 1'b1 == PIXELS) fetch_active <= 1'b0;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: randomized scenarios against a queue-based model of the arbiter,
// with a registered single-port RAM model hanging off the mem_* port.
module tb_vga_vram_arbiter;
    localparam int RX = 8, RY = 2, AW = 6, D = 16, LW = 4, NPIX = RX * RY;

    logic          clk = 0, rst_n = 1;
    logic          frame_start = 0, pix_req = 0, cpu_valid = 0, cpu_we = 0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [31:0]   pix_data, cpu_rdata, mem_wdata, mem_rdata;
    logic          underrun, cpu_ready, cpu_rvalid, mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    vga_vram_arbiter #(.RES_X(RX), .RES_Y(RY), .ADDR_W(AW), .FIFO_DEPTH(D), .LOW_WM(LW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_req(pix_req),
        .pix_data(pix_data), .underrun(underrun), .cpu_valid(cpu_valid), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] salt;
    function automatic logic [31:0] hash(input int i);
        return (32'(i) + 32'd1) * 32'h9E3779B1 ^ salt;
    endfunction

    // RAM contents are reloaded whenever a clock edge sees reset asserted.
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (!rst_n) for (int i = 0; i < 64; i++) ram[i] <= hash(i);
        else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= ram[mem_addr];
    end

    logic [106:0] obs, exp_vec;
    assign obs = {pix_data, underrun, cpu_rvalid, cpu_rdata, cpu_ready, mem_en, mem_we, mem_addr, mem_wdata};

    int total = 0, bad = 0;

    logic [31:0] ram_m [64];
    logic [31:0] q [$];
    logic [31:0] pend_data, cpu_p_data, rd_m;
    bit          pend_d, act, cpu_p, rv_m, ur_m, g_cpu, g_disp;
    int          fp;

    task automatic model_reset();
        q.delete();
        pend_d = 0; act = 0; fp = 0; cpu_p = 0; rv_m = 0; rd_m = '0; ur_m = 0;
        for (int i = 0; i < 64; i++) ram_m[i] = hash(i);
    endtask

    task automatic model_eval();
        int occ;
        bit urgent;
        occ    = q.size() + int'(pend_d);
        urgent = act && occ < LW;
        g_cpu  = cpu_valid && !urgent;
        g_disp = act && !g_cpu && occ < D;
        exp_vec = {(q.size() > 0) ? q[0] : 32'h0, ur_m, rv_m, rd_m, g_cpu, g_cpu | g_disp,
                   g_cpu & cpu_we, g_disp ? 6'(fp) : (g_cpu ? cpu_addr : 6'h0),
                   g_cpu ? cpu_wdata : 32'h0};
    endtask

    task automatic model_clock();
        rv_m = cpu_p;
        if (cpu_p) rd_m = cpu_p_data;
        cpu_p = g_cpu && !cpu_we;
        cpu_p_data = ram_m[cpu_addr];
        if (g_cpu && cpu_we) ram_m[cpu_addr] = cpu_wdata;
        if (frame_start) begin
            q.delete();
            fp = 0; act = 1; pend_d = 0;
        end else begin
            if (pix_req && q.size() == 0) ur_m = 1;
            else if (pix_req) void'(q.pop_front());
            if (pend_d) q.push_back(pend_data);
            pend_d = g_disp;
            if (g_disp) begin
                pend_data = ram_m[fp];
                fp++;
                if (fp == NPIX) act = 0;
            end
        end
    endtask

    task automatic drive(input logic fs, pr, cv, cw, input logic [AW-1:0] ca, input logic [31:0] cd);
        frame_start = fs; pix_req = pr; cpu_valid = cv; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        model_eval();
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_hold got=%h want=0", obs); end
        @(posedge clk); @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, k[0], 6'(k + 20), $urandom);
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", k, obs, exp_vec); end
            advance();
        end
    endtask

    task automatic test_fill();
        drive(1, 0, 0, 0, '0, '0);
        total++;
        if (obs !== exp_vec) begin bad++; $display("FAIL fill_start got=%h want=%h", obs, exp_vec); end
        advance();
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, '0, '0);
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL fill cyc=%0d got=%h want=%h", k, obs, exp_vec); end
            if (k == 2) begin
                total++;
                if (pix_data !== ram_m[0]) begin bad++; $display("FAIL fill_first_pixel got=%h want=%h", pix_data, ram_m[0]); end
            end
            advance();
        end
    endtask

    task automatic test_cpu_rw();
        drive(0, 0, 1, 1, 6'd3, 32'hA5A5_0001);
        total++;
        if (obs !== exp_vec) begin bad++; $display("FAIL cpu_write got=%h want=%h", obs, exp_vec); end
        advance();
        drive(0, 0, 1, 0, 6'd3, '0);
        total++;
        if (obs !== exp_vec) begin bad++; $display("FAIL cpu_read got=%h want=%h", obs, exp_vec); end
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, '0, '0);
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL cpu_idle cyc=%0d got=%h want=%h", k, obs, exp_vec); end
            if (k == 1) begin
                total++;
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5A5_0001) begin
                    bad++; $display("FAIL cpu_readback rvalid=%b data=%h want 1/a5a50001", cpu_rvalid, cpu_rdata);
                end
            end
            advance();
        end
    endtask

    task automatic test_saturate();
        drive(1, 0, 0, 0, '0, '0);
        total++;
        if (obs !== exp_vec) begin bad++; $display("FAIL sat_start got=%h want=%h", obs, exp_vec); end
        advance();
        for (int k = 0; k < 24; k++) begin
            drive(0, k >= 3 && k < 19, 1, 1'($urandom_range(0, 1)), 6'($urandom), $urandom);
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL saturate cyc=%0d got=%h want=%h", k, obs, exp_vec); end
            advance();
        end
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL sat_underrun got=%b want=0", underrun); end
    endtask

    task automatic test_frame_restart();
        drive(1, 0, 0, 0, '0, '0);
        advance();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, '0, '0);
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL restart_pre cyc=%0d got=%h want=%h", k, obs, exp_vec); end
            advance();
        end
        drive(1, 0, 0, 0, '0, '0);
        total++;
        if (obs !== exp_vec) begin bad++; $display("FAIL restart_fs got=%h want=%h", obs, exp_vec); end
        advance();
        for (int k = 0; k < 20; k++) begin
            drive(0, k >= 3 && k < 19, 0, 0, '0, '0);
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL restart cyc=%0d got=%h want=%h", k, obs, exp_vec); end
            if (k == 2) begin
                total++;
                if (pix_data !== ram_m[0]) begin bad++; $display("FAIL restart_first_pixel got=%h want=%h", pix_data, ram_m[0]); end
            end
            advance();
        end
    endtask

    task automatic test_underrun();
        drive(1, 0, 0, 0, '0, '0);
        advance();
        drive(0, 1, 0, 0, '0, '0);
        total++;
        if (obs !== exp_vec || pix_data !== 32'h0) begin
            bad++; $display("FAIL underrun_pop got=%h want=%h", obs, exp_vec);
        end
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(k == 2, 0, 0, 0, '0, '0);
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL underrun cyc=%0d got=%h want=%h", k, obs, exp_vec); end
            advance();
        end
        total++;
        if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky got=%b want=1", underrun); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, '0, '0);
        advance();
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, '0, '0);
            advance();
        end
        drive(0, 0, 1, 0, 6'd9, '0);
        total++;
        if (obs !== exp_vec) begin bad++; $display("FAIL midreset_read got=%h want=%h", obs, exp_vec); end
        advance();
        rst_n = 0;
        frame_start = 0; pix_req = 0; cpu_valid = 0; cpu_we = 0;
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL midreset_async got=%h want=0", obs); end
        model_reset();
        @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, '0, '0);
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL midreset_after cyc=%0d got=%h want=%h", k, obs, exp_vec); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            drive(k == 0 || $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 6'($urandom), $urandom);
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", k, obs, exp_vec); end
            advance();
        end
    endtask

    initial begin
        salt = $urandom;
        model_reset();
        #1 rst_n = 0;
        test_reset();
        test_fill();
        test_cpu_rw();
        test_saturate();
        test_frame_restart();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
